// File: rtl/logic_pkg.sv
// Shared opcode and sequencer-state types for the logic/shift mux command path.
package logic_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_SHR  = 3'b011,
    OP_SHL  = 3'b100,
    OP_ROT  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } seq_state_e;

  function automatic logic is_legal_op(input op_e op);
    return (op != OP_RSV6) && (op != OP_RSV7);
  endfunction

endpackage

// File: rtl/logic_flags.sv
// Combinational zero / sign-bit flags of an N-bit value; shared with the ALU status register.
module logic_flags #(
  parameter int N = 4
) (
  input  logic [N-1:0] value,
  output logic         zero,
  output logic         msb
);

  assign zero = (value == '0);
  assign msb  = value[N-1];

endmodule

// File: rtl/logic_op_sequencer.sv
// Command-side driver for the logic/shift mux: registers a command onto the mux inputs,
// waits one settle cycle, then returns the captured result and flags over valid/ready.
module logic_op_sequencer
  import logic_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [N-1:0]  cmd_a,
  input  logic [N-1:0]  cmd_b,
  output logic [N-1:0]  mux_a,
  output logic [N-1:0]  mux_b,
  output logic [2:0]    mux_sel,
  input  logic [N-1:0]  mux_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          rsp_zero,
  output logic          rsp_msb,
  output logic          rsp_err,
  output logic [CW-1:0] op_count
);

  seq_state_e    state_q, state_d;
  logic [N-1:0]  mux_a_q, mux_a_d;
  logic [N-1:0]  mux_b_q, mux_b_d;
  logic [2:0]    mux_sel_q, mux_sel_d;
  logic [N-1:0]  rsp_data_q, rsp_data_d;
  logic          rsp_zero_q, rsp_zero_d;
  logic          rsp_msb_q, rsp_msb_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [CW-1:0] op_count_q, op_count_d;
  logic          res_zero, res_msb;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic_flags #(.N(N)) u_flags (
    .value (mux_result),
    .zero  (res_zero),
    .msb   (res_msb)
  );

  always_comb begin
    state_d     = state_q;
    mux_a_d     = mux_a_q;
    mux_b_d     = mux_b_q;
    mux_sel_d   = mux_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_msb_d   = rsp_msb_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (is_legal_op(op_e'(cmd_op))) begin
            mux_a_d   = cmd_a;
            mux_b_d   = cmd_b;
            mux_sel_d = cmd_op;
            state_d   = SETTLE;
          end else begin
            // Illegal ops never reach the mux; answer straight away with an error.
            rsp_data_d  = '0;
            rsp_zero_d  = 1'b1;
            rsp_msb_d   = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      SETTLE: begin
        rsp_data_d  = mux_result;
        rsp_zero_d  = res_zero;
        rsp_msb_d   = res_msb;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        op_count_d  = sat_inc(op_count_q);
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mux_a_q     <= '0;
      mux_b_q     <= '0;
      mux_sel_q   <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b1;
      rsp_msb_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      mux_a_q     <= mux_a_d;
      mux_b_q     <= mux_b_d;
      mux_sel_q   <= mux_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_msb_q   <= rsp_msb_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign mux_a     = mux_a_q;
  assign mux_b     = mux_b_q;
  assign mux_sel   = mux_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_msb   = rsp_msb_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;

endmodule
